mux_scan_ctrl: RTL
==================

# mux_scan_ctrl

Sequential select generator and bit collector that sits directly upstream of the `mux8to1` stage. It drives the 3-bit select through all eight positions in a programmable order, waits a settle interval at each position, and samples the selected bit. The sampled bits are reassembled into a parallel word with a ones count, so an 8-bit bus can be scanned through the single-bit mux path under a start/done handshake.

## Interface
- `SETTLE`, default 1: cycles `sel` is held stable before each sample; legal range 1..15.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  scan request; sampled only in IDLE.
- `dir`  input  1  scan order, latched at start: 0 = sel 0→7, 1 = sel 7→0.
- `hold`  input  1  freezes the settle counter and suppresses sampling while high.
- `mux_bit`  input  1  selected bit returned by the mux (`f[0]`).
- `sel`  output  3  mux select.
- `bit_valid`  output  1  high in the cycle `mux_bit` is captured.
- `busy`  output  1  high in SETTLE and SAMPLE.
- `done`  output  1  one-cycle pulse when the scan completes.
- `word_out`  output  8  reassembled word; bit index = `sel` at capture.
- `ones_cnt`  output  4  number of captured 1s (0..8).

## Operation
- Reset (async, `rst_n`=0): state=IDLE, `sel`=0, `bit_valid`=0, `busy`=0, `done`=0, `word_out`=0, `ones_cnt`=0, internal bit counter and settle counter = 0.
- Moore FSM with states IDLE, SETTLE, SAMPLE and DONE. `bit_valid`=(state==SAMPLE), `busy`=(SETTLE or SAMPLE), `done`=(state==DONE).
- IDLE: when `start`=1, latch `dir`, load `sel` (0 if `dir`=0, 7 if `dir`=1), clear `word_out`, `ones_cnt` and the bit counter, load settle counter = SETTLE−1, then go to SETTLE. Otherwise `sel`, `word_out` and `ones_cnt` hold.
- SETTLE: if `hold`=1, stay and freeze the counter. Otherwise, if the counter is 0, go to SAMPLE; else decrement.
- SAMPLE with `hold`=1: stay in SAMPLE and capture nothing. `bit_valid` remains high, but consumers qualify it with `!hold`.
- SAMPLE with `hold`=0: `word_out[sel]` ← `mux_bit`; `ones_cnt` += `mux_bit`.
  - If the bit counter is 7, go to DONE and leave `sel` unchanged.
  - Otherwise, increment the bit counter, step `sel` by +1 (dir 0) or −1 (dir 1), reload the settle counter, and go to SETTLE.
- DONE: lasts one cycle, then returns to IDLE unconditionally. `start` in DONE is ignored.
- `start` while `busy` is ignored. A scan is never restarted or aborted except by reset.
- Arithmetic rules:
  - `sel` stays within 0..7 and never wraps, because exactly 8 samples are taken.
  - `ones_cnt` is 4 bits and saturates naturally at 8.
  - `word_out` is independent of `dir` for static mux data.
- Reset mid-scan: immediately forces all reset values. No `done` is produced for the aborted scan.

## Timing
- Cycle 0 is the cycle whose closing edge accepts `start`.
- With `hold`=0 throughout:
  - bit k (k=0..7) is in SAMPLE during cycle (k+1)(SETTLE+1);
  - `done` is high in cycle 8(SETTLE+1)+1;
  - a new `start` is accepted no earlier than the closing edge of cycle 8(SETTLE+1)+2.
- Each cycle with `hold`=1 in SETTLE or SAMPLE delays all later events by one cycle.
- `sel` changes only on the edge leaving SAMPLE or IDLE, so it is stable for at least SETTLE full cycles before every capture.
- `word_out` and `ones_cnt` are final and stable in the `done` cycle, and hold until the next accepted `start`.

## Test plan
- SETTLE=1, mux fed w=8'hA5, `dir`=0, start at cycle 0:
  - `sel` reads 0,1,…,7;
  - `bit_valid` is high in cycles 2,4,…,16;
  - `done` is high only in cycle 17, with `word_out`=8'hA5 and `ones_cnt`=4.
- SETTLE=3, w=8'h3C, `dir`=1:
  - `sel` reads 7,6,…,0;
  - SAMPLE occurs in cycles 4,8,…,32;
  - `done` is high in cycle 33, with `word_out`=8'h3C and `ones_cnt`=4.
- SETTLE=1, w=8'hFF:
  - assert `hold` for 3 cycles starting in the SAMPLE cycle of bit 2, so bit 2 is captured in cycle 9 instead of 6;
  - `done` is high in cycle 20;
  - `ones_cnt`=8.
- Pulse `start` during cycles 5 and 17 of a SETTLE=1 scan with w=8'h01:
  - both pulses are ignored;
  - exactly one `done` occurs, in cycle 17;
  - `word_out`=8'h01.
- Drive `rst_n`=0 asynchronously mid-cycle 7 of a scan:
  - `sel`, `word_out`, `ones_cnt`, `busy` and `bit_valid` drop to 0 without waiting for a clock edge;
  - no `done` is produced;
  - a fresh `start` after reset release completes normally.
- w=8'h00, then a second scan with w=8'h80:
  - the first scan ends with `ones_cnt`=0 and `word_out`=0;
  - the second starts from cleared `word_out` and ends with `word_out`=8'h80 and `ones_cnt`=1.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mux_scan_ctrl
//  Description : Select generator and bit collector for an 8:1 single-bit
//                mux path. Walks the 3-bit select through all eight
//                positions (ascending or descending), lets each position
//                settle for SETTLE cycles, samples the returned bit and
//                reassembles the samples into a parallel word together with
//                a count of captured ones. Start/done handshake.
//
//  Parameters  : SETTLE    cycles sel is stable before each sample (1..15)
//
//  Ports       : clk       rising-edge clock
//                rst_n     asynchronous active-low reset
//                start     scan request, honoured only while idle
//                dir       scan order latched at start (0: 0->7, 1: 7->0)
//                hold      freezes settle countdown and sampling while high
//                mux_bit   bit returned by the mux for the current sel
//                sel       mux select
//                bit_valid high while in the sample state
//                busy      high while a scan is in progress
//                done      one-cycle completion pulse
//                word_out  reassembled word, bit index = sel at capture
//                ones_cnt  number of captured ones (0..8)
//
//  Revision    : 1.0  initial release
// ============================================================================
module mux_scan_ctrl #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       dir,
    input  logic       hold,
    input  logic       mux_bit,
    output logic [2:0] sel,
    output logic       bit_valid,
    output logic       busy,
    output logic       done,
    output logic [7:0] word_out,
    output logic [3:0] ones_cnt
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_settle = 2'd1;
    localparam logic [1:0] c_sample = 2'd2;
    localparam logic [1:0] c_done   = 2'd3;

    // The countdown runs from SETTLE-1 down to 0, so a position is held for
    // exactly SETTLE cycles in the settle state before the sample cycle.
    localparam logic [3:0] c_settle_load = 4'(SETTLE - 1);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [1:0] r_state;
    logic [1:0] w_state_next;

    logic       r_dir;
    logic [2:0] r_sel;
    logic [2:0] r_bit_cnt;
    logic [3:0] r_settle_cnt;
    logic [7:0] r_word;
    logic [3:0] r_ones;

    // ------------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------------
    logic w_accept;       // start accepted in idle
    logic w_count_down;   // settle countdown advances this cycle
    logic w_capture;      // mux_bit is written into the word this cycle
    logic w_last_bit;     // eighth sample is being taken
    logic [2:0] w_sel_step;

    always_comb begin
        w_accept     = 1'b0;
        w_count_down = 1'b0;
        w_capture    = 1'b0;
        w_last_bit   = (r_bit_cnt == 3'd7);
        w_sel_step   = r_dir ? (r_sel - 3'd1) : (r_sel + 3'd1);
        w_state_next = r_state;

        case (r_state)
            c_idle: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = c_settle;
                end
            end

            c_settle: begin
                // hold freezes everything, including the countdown
                if (!hold) begin
                    if (r_settle_cnt == 4'd0) begin
                        w_state_next = c_sample;
                    end else begin
                        w_count_down = 1'b1;
                    end
                end
            end

            c_sample: begin
                // bit_valid stays high under hold; consumers qualify it
                if (!hold) begin
                    w_capture    = 1'b1;
                    w_state_next = w_last_bit ? c_done : c_settle;
                end
            end

            c_done: begin
                // start is deliberately not looked at here
                w_state_next = c_idle;
            end

            default: begin
                w_state_next = c_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath: select walk, counters and word assembly
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dir        <= 1'b0;
            r_sel        <= 3'd0;
            r_bit_cnt    <= 3'd0;
            r_settle_cnt <= 4'd0;
            r_word       <= 8'd0;
            r_ones       <= 4'd0;
        end else if (w_accept) begin
            r_dir        <= dir;
            r_sel        <= dir ? 3'd7 : 3'd0;
            r_bit_cnt    <= 3'd0;
            r_settle_cnt <= c_settle_load;
            r_word       <= 8'd0;
            r_ones       <= 4'd0;
        end else if (w_count_down) begin
            r_settle_cnt <= r_settle_cnt - 4'd1;
        end else if (w_capture) begin
            r_word[r_sel] <= mux_bit;
            // Eight captures at most, so a 4-bit count never overflows.
            r_ones        <= r_ones + {3'b000, mux_bit};
            if (!w_last_bit) begin
                // sel only moves between positions that still need a sample,
                // so the walk never wraps past 0 or 7.
                r_bit_cnt    <= r_bit_cnt + 3'd1;
                r_sel        <= w_sel_step;
                r_settle_cnt <= c_settle_load;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (Moore)
    // ------------------------------------------------------------------------
    assign sel       = r_sel;
    assign bit_valid = (r_state == c_sample);
    assign busy      = (r_state == c_settle) || (r_state == c_sample);
    assign done      = (r_state == c_done);
    assign word_out  = r_word;
    assign ones_cnt  = r_ones;

endmodule
`default_nettype wire
